// File: rtl/medfilt_stream_ctrl.sv
// Flow controller for the 3x3 median core: AXI-Stream gating, flush
// injection, output re-framing through a 2-entry skid FIFO.
module medfilt_stream_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 512,
    parameter int PIPE_LATENCY = 2 * FRAME_WIDTH + 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tuser,
    input  logic                  s_tlast,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tuser,
    output logic                  m_tlast,
    output logic                  core_en,
    output logic [DATA_WIDTH-1:0] core_din,
    input  logic [DATA_WIDTH-1:0] core_dout,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_sof,
    output logic                  err_eol,
    input  logic                  clr_err
);
    localparam int NPIX = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int NEN  = NPIX + PIPE_LATENCY;
    localparam int IN_W = $clog2(NPIX > 1 ? NPIX : 2);
    localparam int EN_W = $clog2(NEN > 1 ? NEN : 2);
    localparam int CW   = $clog2(FRAME_WIDTH > 1 ? FRAME_WIDTH : 2);
    localparam int RW   = $clog2(FRAME_HEIGHT > 1 ? FRAME_HEIGHT : 2);

    localparam logic [IN_W-1:0] IN_LAST = IN_W'(NPIX - 1);
    localparam logic [EN_W-1:0] EN_LAST = EN_W'(NEN - 1);
    localparam logic [EN_W-1:0] EN_PL   = EN_W'(PIPE_LATENCY);
    localparam logic [CW-1:0]   COL_LAST = CW'(FRAME_WIDTH - 1);
    localparam logic [RW-1:0]   ROW_LAST = RW'(FRAME_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

    state_t                state_q;
    logic [IN_W-1:0]       in_cnt_q;
    logic [CW-1:0]         in_col_q;
    logic [EN_W-1:0]       en_cnt_q;
    logic [CW-1:0]         out_col_q;
    logic [RW-1:0]         out_row_q;
    logic                  inflight_q;
    logic                  cap_q;
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_q;
    logic                  rd_q;
    logic [1:0]            cnt_q;
    logic                  err_sof_q;
    logic                  err_eol_q;

    logic credit, accept, in_phase, push, pop;
    logic sof_bad, eol_bad, out_last;

    // inflight enables reserve a FIFO slot before their result arrives
    assign credit   = ({1'b0, cnt_q} + {2'b00, inflight_q}) < 3'd2;
    assign in_phase = (state_q == IDLE) || (state_q == RUN);
    assign s_tready = rst_n && credit && in_phase;
    assign accept   = s_tvalid && s_tready;

    assign core_en = rst_n && (
        (state_q == IDLE  && accept && s_tuser) ||
        (state_q == RUN   && accept) ||
        (state_q == FLUSH && credit));
    assign core_din = (state_q == FLUSH) ? '0 : s_tdata;

    assign push     = cap_q;
    assign m_tvalid = (cnt_q != 2'd0);
    assign pop      = m_tvalid && m_tready;
    assign m_tdata  = mem_q[rd_q];
    assign m_tuser  = m_tvalid && out_col_q == '0 && out_row_q == '0;
    assign m_tlast  = m_tvalid && out_col_q == COL_LAST;
    assign out_last = out_col_q == COL_LAST && out_row_q == ROW_LAST;

    assign frame_done = (state_q == DRAIN) && pop && out_last;
    assign busy       = (state_q != IDLE);
    assign err_sof    = err_sof_q;
    assign err_eol    = err_eol_q;

    assign sof_bad = accept &&
        ((state_q == IDLE && !s_tuser) || (state_q == RUN && s_tuser));
    assign eol_bad = accept && (s_tlast != (in_col_q == COL_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_cnt_q   <= '0;
            in_col_q   <= '0;
            en_cnt_q   <= '0;
            out_col_q  <= '0;
            out_row_q  <= '0;
            inflight_q <= 1'b0;
            cap_q      <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            cnt_q      <= 2'd0;
            err_sof_q  <= 1'b0;
            err_eol_q  <= 1'b0;
        end else begin
            inflight_q <= core_en;
            cap_q      <= core_en && (en_cnt_q >= EN_PL);

            if (core_en)
                en_cnt_q <= (en_cnt_q == EN_LAST) ? '0 : en_cnt_q + 1'b1;

            if (core_en && in_phase) begin
                in_cnt_q <= (in_cnt_q == IN_LAST) ? '0 : in_cnt_q + 1'b1;
                in_col_q <= (in_col_q == COL_LAST) ? '0 : in_col_q + 1'b1;
            end

            if (push) begin
                mem_q[wr_q] <= core_dout;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q      <= ~rd_q;
                out_col_q <= (out_col_q == COL_LAST) ? '0 : out_col_q + 1'b1;
                if (out_col_q == COL_LAST)
                    out_row_q <= (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};

            // a new error in the clearing cycle still gets recorded
            if (clr_err) begin
                err_sof_q <= 1'b0;
                err_eol_q <= 1'b0;
            end
            if (sof_bad) err_sof_q <= 1'b1;
            if (eol_bad) err_eol_q <= 1'b1;

            unique case (state_q)
                IDLE: begin
                    if (core_en)
                        state_q <= (in_cnt_q == IN_LAST) ? FLUSH : RUN;
                end
                RUN: begin
                    if (core_en && in_cnt_q == IN_LAST)
                        state_q <= FLUSH;
                end
                FLUSH: begin
                    if (core_en && en_cnt_q == EN_LAST)
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    if (frame_done)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_medfilt_stream_ctrl.sv
// Bench for medfilt_stream_ctrl at W=4, H=3, latency 12, with a pure
// delay-line stand-in for the median core.
module tb_medfilt_stream_ctrl;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PL = 12;
    localparam int NP = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tuser = 1'b0;
    logic          s_tlast = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tuser;
    logic          m_tlast;
    logic          core_en;
    logic [DW-1:0] core_din;
    logic [DW-1:0] core_dout = '0;
    logic          busy;
    logic          frame_done;
    logic          err_sof;
    logic          err_eol;
    logic          clr_err = 1'b0;

    medfilt_stream_ctrl #(
        .DATA_WIDTH(DW), .FRAME_WIDTH(W),
        .FRAME_HEIGHT(H), .PIPE_LATENCY(PL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tuser(s_tuser), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tuser(m_tuser), .m_tlast(m_tlast),
        .core_en(core_en), .core_din(core_din), .core_dout(core_dout),
        .busy(busy), .frame_done(frame_done),
        .err_sof(err_sof), .err_eol(err_eol), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // core stand-in: result of enable i is the pixel fed at enable i-PL
    logic [DW-1:0] pipe [PL];
    initial for (int i = 0; i < PL; i++) pipe[i] = '0;
    always @(posedge clk) begin
        if (core_en) begin
            core_dout <= pipe[PL-1];
            for (int i = PL - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= core_din;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // scoreboard: pixels each frame must emerge in order, framed W x H
    int unsigned exp_q[$];
    int oidx = 0;
    int en_n = 0, fl_n = 0, out_n = 0, fd_n = 0, tu_n = 0, tl_n = 0;
    int first_data = -1;
    bit hold = 1'b0;
    logic [DW-1:0] held = '0;
    bit tog = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs",
                int'({s_tready, m_tvalid, m_tuser, m_tlast, core_en,
                      busy, frame_done, err_sof, err_eol}) + int'(m_tdata), 0);
            exp_q.delete();
            oidx = 0;
            hold = 1'b0;
        end else begin
            if (core_en) begin
                en_n++;
                if (!s_tready) begin
                    fl_n++;
                    chk("flush_din", int'(core_din), 0);
                end else begin
                    chk("core_din", int'(core_din), int'(s_tdata));
                end
            end
            if (hold) begin
                chk("hold_valid", int'(m_tvalid), 1);
                chk("hold_data", int'(m_tdata), int'(held));
            end
            hold = m_tvalid && !m_tready;
            held = m_tdata;
            chk("frame_done", int'(frame_done),
                int'(m_tvalid && m_tready && oidx == NP - 1));
            if (frame_done) fd_n++;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    chk("m_tdata", int'(m_tdata), int'(exp_q.pop_front()));
                end
                chk("m_tuser", int'(m_tuser), int'(oidx == 0));
                chk("m_tlast", int'(m_tlast), int'(oidx % W == W - 1));
                if (first_data < 0) first_data = int'(m_tdata);
                if (m_tuser) tu_n++;
                if (m_tlast) tl_n++;
                out_n++;
                oidx = (oidx == NP - 1) ? 0 : oidx + 1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = tog ? ~m_tready : 1'b1;
        end
    end

    int fd_at_first = 0;

    task automatic send_beat(input int d, input bit u, input bit l, input bit scored);
        bit ok = 1'b0;
        bit hs;
        s_tdata  = DW'(d);
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        if (scored) exp_q.push_back(d);
    endtask

    task automatic send_frame(input int base, input int bad_last, input bit keep);
        for (int p = 0; p < NP; p++) begin
            send_beat(base + p + 1, p == 0, (p % W == W - 1) || (p == bad_last), 1'b1);
            if (p == 0) fd_at_first = fd_n;
        end
        if (!keep) s_tvalid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int c = 0; c < 2000 && fd_n < target; c++) @(posedge clk);
        #1;
        chk("frame_done_count", fd_n, target);
    endtask

    int en0, fl0, out0, fd0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: ramp frame, always ready
        en0 = en_n; fl0 = fl_n; out0 = out_n;
        send_frame(0, -1, 1'b0);
        chk("busy_in_flush", int'(busy), 1);
        wait_done(1);
        repeat (2) @(posedge clk);
        #1;
        chk("t1_outputs", out_n - out0, 12);
        chk("t1_enables", en_n - en0, 24);
        chk("t1_flush_en", fl_n - fl0, 12);
        chk("t1_first_data", first_data, 1);
        chk("t1_tuser_n", tu_n, 1);
        chk("t1_tlast_n", tl_n, 3);
        chk("t1_busy", int'(busy), 0);
        chk("t1_err", int'({err_sof, err_eol}), 0);

        // 2: toggled m_tready
        tog = 1'b1;
        out0 = out_n;
        send_frame(0, -1, 1'b0);
        wait_done(2);
        tog = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t2_outputs", out_n - out0, 12);
        chk("t2_busy", int'(busy), 0);

        // 3: stray beat in IDLE is dropped
        en0 = en_n;
        send_beat(77, 1'b0, 1'b0, 1'b0);
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        chk("t3_no_core_en", en_n - en0, 0);
        chk("t3_err_sof", int'(err_sof), 1);
        chk("t3_err_eol", int'(err_eol), 0);
        chk("t3_busy", int'(busy), 0);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        chk("t3_cleared", int'(err_sof), 0);

        // 4: early tlast on pixel 2
        out0 = out_n;
        send_frame(40, 2, 1'b0);
        wait_done(3);
        chk("t4_err_eol", int'(err_eol), 1);
        chk("t4_err_sof", int'(err_sof), 0);
        chk("t4_outputs", out_n - out0, 12);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        chk("t4_cleared", int'(err_eol), 0);

        // 5: reset during flush after 15 enables
        en0 = en_n;
        send_frame(60, -1, 1'b0);
        for (int c = 0; c < 500 && en_n - en0 < 15; c++) @(posedge clk);
        chk("t5_reached_15", en_n - en0, 15);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_async_clear",
            int'({m_tvalid, core_en, busy, s_tready}) + int'(m_tdata), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fd0 = fd_n;
        out0 = out_n;
        send_frame(80, -1, 1'b0);
        wait_done(fd0 + 1);
        chk("t5_outputs", out_n - out0, 12);

        // 6: back-to-back frames with s_tvalid held high
        fd0 = fd_n;
        out0 = out_n;
        tu_n = 0;
        send_frame(100, -1, 1'b1);
        send_frame(150, -1, 1'b1);
        chk("t6_gap_tready", fd_at_first, fd0 + 1);
        s_tvalid = 1'b0;
        wait_done(fd0 + 2);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_outputs", out_n - out0, 24);
        chk("t6_tuser_n", tu_n, 2);
        chk("t6_fifo_empty", int'(m_tvalid), 0);
        chk("t6_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
